// File: rtl/sevenseg_sign_reader.sv
// Seven-segment sign/magnitude reader: samples the active-low two-digit bus,
// waits for it to hold steady, decodes it to a 4-bit two's-complement value
// and hands each new value out over valid/ready. Illegal patterns are counted.
module sevenseg_sign_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg1,
    input  logic [6:0]       seg0,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [3:0]       out_value,
    output logic             out_valid,
    output logic             err,
    output logic             ovf,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [13:0] BLANK    = 14'h3FFF;
    localparam logic [7:0]  STABLE_N = 8'(STABLE_CYCLES);

    state_t      state, state_nxt;
    logic [13:0] samp, prev;
    logic [7:0]  cnt, cnt_nxt;
    logic        dec_fire;
    logic        dec_ok;
    logic [3:0]  dec_val;

    // Magnitude digit lookup: {legal, magnitude}
    function automatic logic [4:0] mag_lookup(input logic [6:0] s);
        case (s)
            7'b0000001: mag_lookup = {1'b1, 4'd0};
            7'b1001111: mag_lookup = {1'b1, 4'd1};
            7'b0010010: mag_lookup = {1'b1, 4'd2};
            7'b0000110: mag_lookup = {1'b1, 4'd3};
            7'b1001100: mag_lookup = {1'b1, 4'd4};
            7'b0100100: mag_lookup = {1'b1, 4'd5};
            7'b0100000: mag_lookup = {1'b1, 4'd6};
            7'b0001111: mag_lookup = {1'b1, 4'd7};
            7'b0000000: mag_lookup = {1'b1, 4'd8};
            default:    mag_lookup = {1'b0, 4'd0};
        endcase
    endfunction

    // Combine sign and magnitude; negative zero and positive eight are illegal
    always_comb begin
        logic [4:0] m;
        m       = mag_lookup(samp[6:0]);
        dec_ok  = 1'b0;
        dec_val = 4'd0;
        if (m[4]) begin
            if (samp[13:7] == 7'b1111111 && m[3:0] != 4'd8) begin
                dec_ok  = 1'b1;
                dec_val = m[3:0];
            end else if (samp[13:7] == 7'b1111110 && m[3:0] != 4'd0) begin
                dec_ok  = 1'b1;
                dec_val = 4'd0 - m[3:0];
            end
        end
    end

    // Input sample register and one-sample history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= BLANK;
            prev <= BLANK;
        end else begin
            samp <= {seg1, seg0};
            prev <= samp;
        end
    end

    // FSM state and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: count identical samples, fire one decode when stable
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dec_fire  = 1'b0;
        if (samp == BLANK) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else if (state == SETTLE && samp == prev) begin
            cnt_nxt = cnt + 8'd1;
            if (cnt + 8'd1 == STABLE_N) begin
                dec_fire  = 1'b1;
                state_nxt = HOLD;
            end
        end else if (state == HOLD && samp == prev) begin
            state_nxt = HOLD;
        end else begin
            // Fresh non-blank pattern: this sample is the first of the run
            cnt_nxt = 8'd1;
            if (STABLE_N == 8'd1) begin
                dec_fire  = 1'b1;
                state_nxt = HOLD;
            end else begin
                state_nxt = SETTLE;
            end
        end
    end

    // Output handshake: new decode wins over transfer, ovf on unconsumed overwrite
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_value <= 4'd0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (dec_fire && dec_ok) begin
                out_value <= dec_val;
                out_valid <= 1'b1;
                ovf       <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Error pulse and saturating counter; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= dec_fire && !dec_ok;
            if (clr_err)
                err_count <= '0;
            else if (dec_fire && !dec_ok && err_count != {ERR_W{1'b1}})
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_sevenseg_sign_reader.sv
// Bench for sevenseg_sign_reader: table-driven sweep through a scoreboard,
// plus directed sequences for latency, glitches, errors, backpressure, reset.
module tb_sevenseg_sign_reader;

    localparam logic [6:0] POS = 7'b1111111;
    localparam logic [6:0] NEG = 7'b1111110;

    logic       clk, rst_n;
    logic [6:0] seg1, seg0;
    logic       out_ready, clr_err;
    logic [3:0] out_value;
    logic       out_valid, err, ovf;
    logic [7:0] err_count;

    sevenseg_sign_reader #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg1(seg1), .seg0(seg0),
        .out_ready(out_ready), .clr_err(clr_err),
        .out_value(out_value), .out_valid(out_valid), .err(err),
        .ovf(ovf), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] s1;
        logic [6:0] s0;
        logic       is_err;
        logic [3:0] val;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [3:0] val;
    } exp_t;

    vec_t vt[19];
    exp_t sb_q[$];
    int   total = 0;
    int   passed = 0;
    int   err_pulses = 0;
    int   ovf_pulses = 0;
    logic sb_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [6:0] s1, input logic [6:0] s0);
        seg1 = s1;
        seg0 = s0;
    endtask

    // Monitor: count pulses always; scoreboard pops on err or transfer
    always @(negedge clk) begin
        if (err) err_pulses++;
        if (ovf) ovf_pulses++;
        if (sb_en && (err || (out_valid && out_ready))) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: err=%0b value=%0h with empty queue", err, out_value);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_is_err", {31'd0, err}, {31'd0, e.is_err});
                if (!e.is_err) chk("sb_value", {28'd0, out_value}, {28'd0, e.val});
            end
        end
        if (sb_en && ovf) chk("sb_no_ovf", {31'd0, ovf}, 32'd0);
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        vt[0]  = '{POS, 7'b0000001, 1'b0, 4'h0};
        vt[1]  = '{POS, 7'b1001111, 1'b0, 4'h1};
        vt[2]  = '{POS, 7'b0010010, 1'b0, 4'h2};
        vt[3]  = '{POS, 7'b0000110, 1'b0, 4'h3};
        vt[4]  = '{POS, 7'b1001100, 1'b0, 4'h4};
        vt[5]  = '{POS, 7'b0100100, 1'b0, 4'h5};
        vt[6]  = '{POS, 7'b0100000, 1'b0, 4'h6};
        vt[7]  = '{POS, 7'b0001111, 1'b0, 4'h7};
        vt[8]  = '{NEG, 7'b1001111, 1'b0, 4'hF};
        vt[9]  = '{NEG, 7'b0010010, 1'b0, 4'hE};
        vt[10] = '{NEG, 7'b0000110, 1'b0, 4'hD};
        vt[11] = '{NEG, 7'b1001100, 1'b0, 4'hC};
        vt[12] = '{NEG, 7'b0100100, 1'b0, 4'hB};
        vt[13] = '{NEG, 7'b0100000, 1'b0, 4'hA};
        vt[14] = '{NEG, 7'b0001111, 1'b0, 4'h9};
        vt[15] = '{NEG, 7'b0000000, 1'b0, 4'h8};
        vt[16] = '{POS, 7'b1010101, 1'b1, 4'h0};
        vt[17] = '{7'b0000000, 7'b0000001, 1'b1, 4'h0};
        vt[18] = '{NEG, 7'b0000001, 1'b1, 4'h0};

        rst_n = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        drive(POS, 7'b1111111);
        #12;
        chk("rst_value", {28'd0, out_value}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        ticks(2);

        // Latency: +7 valid on the 5th edge, cleared by ready, not re-emitted
        drive(POS, 7'b0001111);
        ticks(4);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_value", {28'd0, out_value}, 32'h7);
        out_ready = 1'b1;
        tick();
        chk("lat_cleared", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        ticks(8);
        chk("lat_no_reemit", {31'd0, out_valid}, 32'd0);

        // Glitch: +3 for 3 cycles then +5; only +5 after 4 stable samples
        drive(POS, 7'b0000110);
        ticks(3);
        drive(POS, 7'b0100100);
        ticks(4);
        chk("glitch_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("glitch_valid", {31'd0, out_valid}, 32'd1);
        chk("glitch_value", {28'd0, out_value}, 32'h5);

        // Illegal: negative zero then positive eight
        base = err_pulses;
        drive(NEG, 7'b0000001);
        ticks(6);
        drive(POS, 7'b0000000);
        ticks(6);
        chk("ill_pulses", err_pulses - base, 32'd2);
        chk("ill_count", {24'd0, err_count}, 32'd2);
        chk("ill_valid_kept", {31'd0, out_valid}, 32'd1);
        chk("ill_value_kept", {28'd0, out_value}, 32'h5);

        // Saturation: 300 illegal events alternating two patterns
        base = err_pulses;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive(NEG, 7'b0000001);
            else drive(POS, 7'b0000000);
            ticks(6);
        end
        chk("sat_pulses", err_pulses - base, 32'd300);
        chk("sat_count", {24'd0, err_count}, 32'd255);

        // clr_err on the same edge as an error: clear wins, err still pulses
        drive(7'b0000000, 7'b1010101);
        ticks(4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err_pulse", {31'd0, err}, 32'd1);
        chk("clr_count", {24'd0, err_count}, 32'd0);

        // Backpressure: +2 then -4 unconsumed -> -4 wins, one ovf
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        base = ovf_pulses;
        drive(POS, 7'b0010010);
        ticks(6);
        drive(NEG, 7'b1001100);
        ticks(6);
        chk("bp_value", {28'd0, out_value}, 32'hC);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_ovf", ovf_pulses - base, 32'd1);
        // Ready on the same edge as a new decode: no ovf, valid stays
        drive(POS, 7'b0100000);
        ticks(4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("same_edge_valid", {31'd0, out_valid}, 32'd1);
        chk("same_edge_value", {28'd0, out_value}, 32'h6);
        ticks(2);
        chk("same_edge_no_ovf", ovf_pulses - base, 32'd1);

        // Blank: no error, no valid
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        base = err_pulses;
        drive(POS, 7'b1111111);
        ticks(8);
        chk("blank_no_err", err_pulses - base, 32'd0);
        chk("blank_no_valid", {31'd0, out_valid}, 32'd0);

        // Table sweep through the scoreboard
        out_ready = 1'b1;
        sb_en = 1'b1;
        for (int i = 0; i < 19; i++) begin
            exp_t e;
            e.is_err = vt[i].is_err;
            e.val    = vt[i].val;
            drive(vt[i].s1, vt[i].s0);
            sb_q.push_back(e);
            ticks(6);
        end
        ticks(2);
        sb_en = 1'b0;
        chk("sb_drained", sb_q.size(), 32'd0);
        out_ready = 1'b0;

        // Reset mid-SETTLE: outputs clear at once, fresh 4 samples needed
        drive(POS, 7'b1001111);
        ticks(6);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        drive(POS, 7'b0100100);
        ticks(2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_value", {28'd0, out_value}, 32'd0);
        chk("mid_rst_count", {24'd0, err_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        ticks(4);
        chk("post_rst_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_value", {28'd0, out_value}, 32'h5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
